// File: rtl/hwpe_stream_package.sv
// Shared HWPE stream types: FIFO occupancy flags exported to the controller.
package hwpe_stream_package;

    // Sized for FIFO_DEPTH up to 256 (count range 0..256).
    localparam int unsigned FIFO_MAX_DEPTH  = 256;
    localparam int unsigned FIFO_CNT_WIDTH  = $clog2(FIFO_MAX_DEPTH + 1);

    typedef struct packed {
        logic                      empty;
        logic                      full;
        logic                      almost_full;
        logic [FIFO_CNT_WIDTH-1:0] count;
    } flags_fifo_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream carrying data plus byte strobe.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input  ready);
    modport sink   (input  valid, input  data, input  strb, output ready);

endinterface

// File: rtl/hwpe_stream_fifo_sc.sv
// Single-clock elastic FIFO: registered storage, no fall-through, ready/valid
// derived only from the registered occupancy count.
module hwpe_stream_fifo_sc
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    hwpe_stream_intf_stream.sink          push_i,
    hwpe_stream_intf_stream.source        pop_o,
    output flags_fifo_t                   flags_o
);

    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned ENTRY_WIDTH = DATA_WIDTH + STRB_WIDTH;
    localparam int unsigned PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_WIDTH   = $clog2(FIFO_DEPTH + 1);

    logic [ENTRY_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wp_q, wp_d;
    logic [PTR_WIDTH-1:0]   rp_q, rp_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic push_ready;
    logic pop_valid;
    logic push_ok;
    logic pop_ok;

    // Modulo-FIFO_DEPTH increment; explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        if (p == PTR_WIDTH'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return PTR_WIDTH'(p + 1'b1);
    endfunction

    // Handshakes depend only on registered count: no ready->ready or push->pop paths.
    assign push_ready   = (cnt_q != CNT_WIDTH'(FIFO_DEPTH));
    assign pop_valid    = (cnt_q != '0);
    assign push_ok      = push_i.valid & push_ready;
    assign pop_ok       = pop_valid & pop_o.ready;

    assign push_i.ready = push_ready;
    assign pop_o.valid  = pop_valid;
    assign {pop_o.strb, pop_o.data} = mem_q[rp_q];

    // Next pointer/count; clear discards any same-cycle handshake.
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) begin
                wp_d = ptr_inc(wp_q);
            end
            if (pop_ok) begin
                rp_d = ptr_inc(rp_q);
            end
            if (push_ok && !pop_ok) begin
                cnt_d = CNT_WIDTH'(cnt_q + 1'b1);
            end else if (pop_ok && !push_ok) begin
                cnt_d = CNT_WIDTH'(cnt_q - 1'b1);
            end
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) begin
            mem_q[wp_q] <= {push_i.strb, push_i.data};
        end
    end

    // Occupancy flags, functions of registered count only.
    always_comb begin
        flags_o             = '0;
        flags_o.empty       = (cnt_q == '0);
        flags_o.full        = (cnt_q == CNT_WIDTH'(FIFO_DEPTH));
        flags_o.almost_full = (cnt_q >= CNT_WIDTH'(FIFO_DEPTH - 1));
        flags_o.count       = FIFO_CNT_WIDTH'(cnt_q);
    end

endmodule

// File: tb/tb_hwpe_stream_fifo_sc.sv
// Bench for hwpe_stream_fifo_sc: depth-8 and depth-5 instances against a queue model.
module tb_hwpe_stream_fifo_sc;
    import hwpe_stream_package::*;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned EW = DW + SW;

    logic clk;
    logic rst_n;

    logic          clear     [2];
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [DW-1:0] in_data   [2];
    logic [SW-1:0] in_strb   [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [DW-1:0] out_data  [2];
    logic [SW-1:0] out_strb  [2];
    flags_fifo_t   flags     [2];

    int tests;
    int fails;
    int cur;
    bit hold;
    logic [EW-1:0] mq [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int unsigned D = (g == 0) ? 8 : 5;
        hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push ();
        hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop ();
        assign push.valid   = in_valid[g];
        assign push.data    = in_data[g];
        assign push.strb    = in_strb[g];
        assign in_ready[g]  = push.ready;
        assign out_valid[g] = pop.valid;
        assign out_data[g]  = pop.data;
        assign out_strb[g]  = pop.strb;
        assign pop.ready    = out_ready[g];
        hwpe_stream_fifo_sc #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) i_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .clear_i (clear[g]),
            .push_i  (push),
            .pop_o   (pop),
            .flags_o (flags[g])
        );
    end

    // Upstream protocol: a stalled push keeps valid high and data stable.
    logic          pend [2];
    logic [DW-1:0] pdat [2];
    initial begin
        pend[0] = 1'b0;
        pend[1] = 1'b0;
    end
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n && pend[i]) begin
                assert (in_valid[i] && in_data[i] == pdat[i])
                    else $error("push protocol broken on dut %0d", i);
            end
            pend[i] <= rst_n && in_valid[i] && !in_ready[i] && !clear[i];
            pdat[i] <= in_data[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut=%0d got=%0h exp=%0h", tag, cur, got, exp);
        end
    endtask

    function automatic int dep();
        return (cur == 0) ? 8 : 5;
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            clear[i]     = 1'b0;
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            in_strb[i]   = '0;
            out_ready[i] = 1'b0;
        end
        hold = 1'b0;
    endtask

    task automatic check_state();
        logic [EW-1:0] w;
        int n;
        n = mq.size();
        chk("pop_valid", 64'(out_valid[cur]), 64'(n != 0));
        if (n != 0) begin
            w = mq[0];
            chk("pop_data", 64'(out_data[cur]), 64'(w[DW-1:0]));
            chk("pop_strb", 64'(out_strb[cur]), 64'(w[EW-1:DW]));
        end
        chk("empty", 64'(flags[cur].empty), 64'(n == 0));
        chk("full", 64'(flags[cur].full), 64'(n == dep()));
        chk("almost_full", 64'(flags[cur].almost_full), 64'(n >= dep() - 1));
        chk("count", 64'(flags[cur].count), 64'(n));
    endtask

    // One clock: predict handshakes from the model, advance, compare.
    task automatic cycle();
        bit pa;
        bit pp;
        logic [EW-1:0] w;
        chk("push_ready", 64'(in_ready[cur]), 64'(mq.size() < dep()));
        pa = in_valid[cur] && (mq.size() < dep());
        pp = out_ready[cur] && (mq.size() != 0);
        w  = {in_strb[cur], in_data[cur]};
        @(posedge clk);
        if (clear[cur]) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (pa) mq.push_back(w);
        end
        hold = in_valid[cur] && !pa;
        #1;
        check_state();
    endtask

    task automatic set_push(input bit v, input logic [DW-1:0] d, input logic [SW-1:0] s);
        in_valid[cur] = v;
        in_data[cur]  = d;
        in_strb[cur]  = s;
    endtask

    task automatic rand_inputs(input int pv, input int pr);
        if (!hold) begin
            set_push(($urandom % 100) < pv, DW'($urandom), SW'($urandom));
        end
        out_ready[cur] = ($urandom % 100) < pr;
    endtask

    // Asynchronous reset pulse mid-cycle; returns at posedge+1.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        mq.delete();
        idle_all();
        #1;
        chk("rst_pop_valid", 64'(out_valid[cur]), 64'(0));
        chk("rst_push_ready", 64'(in_ready[cur]), 64'(1));
        check_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cur   = 0;
        rst_n = 1'b0;
        idle_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_state();

        // Push A,B,C with pop stalled, then drain in order.
        cur = 0;
        set_push(1'b1, 32'hA, 4'h1); cycle();
        chk("first_visible", 64'(out_data[0]), 64'hA);
        set_push(1'b1, 32'hB, 4'h3); cycle();
        set_push(1'b1, 32'hC, 4'h7); cycle();
        set_push(1'b0, 32'h0, 4'h0);
        chk("abc_count", 64'(flags[0].count), 64'd3);
        out_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("abc_empty", 64'(flags[0].empty), 64'd1);
        out_ready[0] = 1'b0;

        // Fill to full, hold a 9th word, pop at full.
        for (int i = 0; i < 8; i++) begin
            set_push(1'b1, DW'(32'h100 + i), SW'(i));
            cycle();
        end
        chk("full_flag", 64'(flags[0].full), 64'd1);
        set_push(1'b1, 32'h999, 4'hF);
        cycle();
        cycle();
        chk("ninth_held", 64'(in_ready[0]), 64'd0);
        out_ready[0] = 1'b1;
        cycle();
        chk("full_pop_count", 64'(flags[0].count), 64'd7);
        out_ready[0] = 1'b0;
        chk("ready_back", 64'(in_ready[0]), 64'd1);
        cycle();
        chk("ninth_written", 64'(flags[0].count), 64'd8);
        set_push(1'b0, '0, '0);

        // Clear during a push handshake at count 4.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, DW'(32'h200 + i), 4'h5);
            cycle();
        end
        set_push(1'b1, 32'hDEAD, 4'hA);
        clear[0] = 1'b1;
        cycle();
        clear[0] = 1'b0;
        chk("clr_count", 64'(flags[0].count), 64'd0);
        chk("clr_valid", 64'(out_valid[0]), 64'd0);
        set_push(1'b1, 32'hBEEF, 4'h6);
        cycle();
        set_push(1'b0, '0, '0);
        chk("clr_next_word", 64'(out_data[0]), 64'hBEEF);
        out_ready[0] = 1'b1;
        cycle();
        out_ready[0] = 1'b0;

        // Sustained push+pop at count 2.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_push(1'b1, DW'($urandom), SW'($urandom));
            cycle();
        end
        out_ready[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            set_push(1'b1, DW'($urandom), SW'($urandom));
            cycle();
            chk("stream_count", 64'(flags[0].count), 64'd2);
        end
        idle_all();

        // Depth 5: stream with random pop readiness, then random traffic.
        do_reset();
        cur = 1;
        for (int i = 0; i < 20; i++) begin
            set_push(1'b1, DW'(32'h300 + i), SW'(i));
            out_ready[1] = $urandom % 2;
            cycle();
            while (hold) begin
                out_ready[1] = $urandom % 2;
                cycle();
            end
        end
        set_push(1'b0, '0, '0);
        out_ready[1] = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("d5_drained", 64'(flags[1].empty), 64'd1);
        for (int i = 0; i < 300; i++) begin
            rand_inputs(70, 50);
            cycle();
        end
        idle_all();

        // Depth 8: random traffic with occasional clear and a mid-burst reset.
        cur = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            rand_inputs(60, 55);
            clear[0] = ($urandom % 100) < 2;
            cycle();
            clear[0] = 1'b0;
            if (i == 150) do_reset();
        end
        idle_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_fifo_sc.md
# hwpe_stream_fifo_sc

Single-clock, synchronous-read elastic FIFO for HWPE streams. It sits directly downstream of the TCDM source's output stream and decouples the source's burst of TCDM responses from the engine datapath that consumes it. Backpressure from the engine is absorbed here, so source-side stalls do not propagate combinationally from the engine. It carries data plus byte strobe, and exposes occupancy flags to the controller.

## Interface
Parameters:
- DATA_WIDTH, 32, stream data width in bits (multiple of 8).
- FIFO_DEPTH, 8, number of entries; any integer ≥ 2 (power of two not required).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low.
- clear_i  in  1  synchronous clear, same priority as reset, effective at next edge.
- push_i  hwpe_stream_intf_stream.sink  DATA_WIDTH + DATA_WIDTH/8  input stream (valid, ready, data, strb).
- pop_o  hwpe_stream_intf_stream.source  DATA_WIDTH + DATA_WIDTH/8  output stream (valid, ready, data, strb).
- flags_o  out  flags_fifo_t  {empty, full, almost_full, count[$clog2(FIFO_DEPTH+1)-1:0]}.

## Operation
- Storage: FIFO_DEPTH-entry register array of {data, strb}; write pointer wp, read pointer rp, occupancy count cnt, all $clog2(FIFO_DEPTH) / $clog2(FIFO_DEPTH+1) bits.
- Push handshake: push_i.ready = (cnt != FIFO_DEPTH). Transfer when push_i.valid & push_i.ready; entry written at wp, wp advances.
- Pop handshake: pop_o.valid = (cnt != 0); pop_o.data/strb = array[rp] (combinational read of registered storage). Transfer when pop_o.valid & pop_o.ready; rp advances.
- Pointer wrap: wp/rp increment modulo FIFO_DEPTH (explicit compare to FIFO_DEPTH-1, reset to 0), correct for non-power-of-two depth.
- cnt: +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop or on neither.
- No fall-through: a word pushed into an empty FIFO is visible on pop_o only from the next cycle.
- Full: push_i.ready low even if pop occurs in the same cycle (ready depends only on registered cnt; no combinational ready→ready path).
- Empty: pop_o.valid low; pop_o.ready ignored.
- Simultaneous push and pop at 0 < cnt < FIFO_DEPTH: both accepted, cnt unchanged.
- flags_o: empty = (cnt==0), full = (cnt==FIFO_DEPTH), almost_full = (cnt ≥ FIFO_DEPTH-1), count = cnt; all pure functions of registered state.
- valid stability: once pop_o.valid is high it stays high with stable data until pop_o.ready; the same is required of push_i (protocol assertion in bench).

## Timing
- Reset (rst_ni low, asynchronous): wp=rp=cnt=0; pop_o.valid=0, push_i.ready=1, flags_o.empty=1, full=0, almost_full=0, count=0. Storage array not reset; pop_o.data/strb undefined-but-driven (reset value '0 permitted, not required).
- clear_i high at an edge: same state as reset after that edge; a push or pop handshake in the same cycle is discarded (no pointer/count effect).
- Reset or clear mid-burst: all stored words lost; no spurious pop_o.valid afterwards.
- Latency push→pop: 1 cycle minimum. Throughput: 1 word/cycle sustained with both sides active.
- No combinational path from push_i to pop_o or from pop_o.ready to push_i.ready.

## Structure
- flags_fifo_t (empty, full, almost_full, count) added to hwpe_stream_package; count width fixed to the package-wide max (sized for FIFO_DEPTH ≤ 256), upper bits zero.
- No sub-module: storage, pointers and counter are inline; the whole block is a single module.

## Test plan
- Reset then push 3 words (0xA, 0xB, 0xC) with pop_o.ready=0 → count=3, pop_o.valid=1 with data 0xA from cycle after first push; releasing ready pops A,B,C in order, then empty=1.
- FIFO_DEPTH=8, push 8 words with ready=0 → full=1, push_i.ready=0; 9th valid word held upstream, not written; one pop → ready returns next cycle.
- FIFO_DEPTH=5 (non power of two), stream 20 words with random pop_o.ready → output sequence equals input, pointers wrap correctly, no loss/duplication.
- Full FIFO with push_i.valid=1 and pop_o.ready=1 same cycle → pop accepted, push rejected, count goes 8→7.
- Count=4, assert clear_i during a push handshake → next cycle count=0, empty=1, pop_o.valid=0, pushed word absent.
- Continuous push and pop at count=2 for 50 cycles → count stays 2, one word/cycle throughput, strb bits preserved per word.
